// File: rtl/result_unpacker.sv
// -----------------------------------------------------------------------------
// result_unpacker
//
// Reads packed result words from the dual-SRAM result region through the
// read-only SRAM port and streams them out one DATA_W result at a time over a
// valid/ready interface. Each packed word is {sram_B, sram_A}: the low half is
// delivered first, then the high half.
//
// Ports
//   clk_i         rising-edge clock
//   rst_i         asynchronous, active-high reset
//   start_i       start request, sampled only while idle
//   start_addr_i  first word address, latched on start
//   end_addr_i    last word address (inclusive), latched on start
//   csb_o         SRAM read-port chip select, active-low
//   addr_o        SRAM read-port address
//   rdata_i       packed read data {sram_B.dout1, sram_A.dout1}
//   res_valid_o   result valid
//   res_data_o    result data
//   res_ready_i   consumer ready
//   busy_o        high whenever a transfer is in progress (including DONE)
//   done_o        one-cycle pulse after the last result has been accepted
// -----------------------------------------------------------------------------
module result_unpacker #(
    parameter int ADDR_W        = 9,
    parameter int DATA_W        = 32,
    parameter int MEM_WORD_SIZE = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [ADDR_W-1:0]        start_addr_i,
    input  logic [ADDR_W-1:0]        end_addr_i,
    output logic                     csb_o,
    output logic [ADDR_W-1:0]        addr_o,
    input  logic [MEM_WORD_SIZE-1:0] rdata_i,
    output logic                     res_valid_o,
    output logic [DATA_W-1:0]        res_data_o,
    input  logic                     res_ready_i,
    output logic                     busy_o,
    output logic                     done_o
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WT   = 3'd2,
        ST_LO   = 3'd3,
        ST_HI   = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    state_t                           state_r;
    logic [ADDR_W-1:0]                cur_r;
    logic [ADDR_W-1:0]                end_r;
    // The low half of the packed word goes straight into res_data_o when the
    // word is captured, so only the high half needs its own holding register.
    logic [MEM_WORD_SIZE-DATA_W-1:0]  word_hi_r;

    // Transfer sequencer: all outputs are registered and computed one state ahead.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            cur_r       <= {ADDR_W{1'b0}};
            end_r       <= {ADDR_W{1'b0}};
            word_hi_r   <= {(MEM_WORD_SIZE-DATA_W){1'b0}};
            csb_o       <= 1'b1;
            addr_o      <= {ADDR_W{1'b0}};
            res_valid_o <= 1'b0;
            res_data_o  <= {DATA_W{1'b0}};
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            // done_o is a pulse: cleared every cycle unless HI sets it below.
            done_o <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_i) begin
                        cur_r   <= start_addr_i;
                        end_r   <= end_addr_i;
                        addr_o  <= start_addr_i;
                        csb_o   <= 1'b0;
                        busy_o  <= 1'b1;
                        state_r <= ST_RD;
                    end
                end
                ST_RD: begin
                    // The SRAM samples csb/addr at the edge leaving RD.
                    csb_o   <= 1'b1;
                    state_r <= ST_WT;
                end
                ST_WT: begin
                    // Read data is valid during WT; capture it on the way out.
                    word_hi_r   <= rdata_i[MEM_WORD_SIZE-1:DATA_W];
                    res_data_o  <= rdata_i[DATA_W-1:0];
                    res_valid_o <= 1'b1;
                    state_r     <= ST_LO;
                end
                ST_LO: begin
                    if (res_ready_i) begin
                        res_data_o <= word_hi_r;
                        state_r    <= ST_HI;
                    end
                end
                ST_HI: begin
                    if (res_ready_i) begin
                        res_valid_o <= 1'b0;
                        if (cur_r == end_r) begin
                            done_o  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            // Natural ADDR_W-bit overflow gives the wrap to 0.
                            cur_r   <= cur_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                            addr_o  <= cur_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                            csb_o   <= 1'b0;
                            state_r <= ST_RD;
                        end
                    end
                end
                ST_DONE: begin
                    busy_o  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    csb_o       <= 1'b1;
                    res_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_unpacker.sv
module tb_result_unpacker;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [8:0]  start_addr_i;
    logic [8:0]  end_addr_i;
    logic        csb_o;
    logic [8:0]  addr_o;
    logic [63:0] rdata_i;
    logic        res_valid_o;
    logic [31:0] res_data_o;
    logic        res_ready_i;
    logic        busy_o;
    logic        done_o;

    int tests = 0;
    int fails = 0;
    int res_cnt = 0;
    int csb_cnt = 0;
    int done_cnt = 0;
    logic prev_done = 1'b0;

    logic [63:0] mem [0:511];
    logic [31:0] exp_q [$];
    logic [8:0]  addr_q [$];

    result_unpacker dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start_i),
        .start_addr_i (start_addr_i),
        .end_addr_i   (end_addr_i),
        .csb_o        (csb_o),
        .addr_o       (addr_o),
        .rdata_i      (rdata_i),
        .res_valid_o  (res_valid_o),
        .res_data_o   (res_data_o),
        .res_ready_i  (res_ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM read-port model: one-cycle read latency.
    always @(posedge clk) begin
        if (!csb_o) rdata_i <= mem[addr_o];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (res_valid_o && res_ready_i) begin
                res_cnt++;
                check("result_pending", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) check("result_data", {32'd0, res_data_o}, {32'd0, exp_q.pop_front()});
            end
            if (!csb_o) begin
                csb_cnt++;
                check("read_pending", 64'(addr_q.size() > 0), 64'd1);
                if (addr_q.size() > 0) check("read_addr", {55'd0, addr_o}, {55'd0, addr_q.pop_front()});
            end
            if (done_o) begin
                done_cnt++;
                check("done_busy", {63'd0, busy_o}, 64'd1);
                check("done_single", {63'd0, prev_done}, 64'd0);
            end
            prev_done = done_o;
        end else begin
            prev_done = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic [8:0] s, input logic [8:0] e);
        logic [8:0] a;
        a = s;
        for (int i = 0; i < 512; i++) begin
            addr_q.push_back(a);
            exp_q.push_back(mem[a][31:0]);
            exp_q.push_back(mem[a][63:32]);
            if (a == e) break;
            a = a + 9'd1;
        end
        start_i = 1'b1;
        start_addr_i = s;
        end_addr_i = e;
        step();
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy_o && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check("wait_idle", {63'd0, ok}, 64'd1);
    endtask

    initial begin
        int d0, c0, r0;
        logic [31:0] held;
        logic found;

        for (int i = 0; i < 512; i++) mem[i] = {32'hB000_0000 | i, 32'hA000_0000 | i};
        mem[9'h010] = 64'hBBBB_0002_AAAA_0001;
        rst = 1'b1;
        start_i = 1'b0;
        start_addr_i = 9'd0;
        end_addr_i = 9'd0;
        res_ready_i = 1'b1;
        rdata_i = 64'd0;
        step();
        step();

        // Reset state
        check("rst_csb", {63'd0, csb_o}, 64'd1);
        check("rst_addr", {55'd0, addr_o}, 64'd0);
        check("rst_valid", {63'd0, res_valid_o}, 64'd0);
        check("rst_data", {32'd0, res_data_o}, 64'd0);
        check("rst_busy", {63'd0, busy_o}, 64'd0);
        check("rst_done", {63'd0, done_o}, 64'd0);
        rst = 1'b0;
        step();

        // Single word, latency
        d0 = done_cnt;
        start_xfer(9'h010, 9'h010);
        check("lat_busy", {63'd0, busy_o}, 64'd1);
        check("lat_rd_csb", {63'd0, csb_o}, 64'd0);
        check("lat_rd_addr", {55'd0, addr_o}, 64'h010);
        check("lat_valid0", {63'd0, res_valid_o}, 64'd0);
        step();
        check("lat_wt_csb", {63'd0, csb_o}, 64'd1);
        check("lat_valid1", {63'd0, res_valid_o}, 64'd0);
        step();
        check("lat_valid2", {63'd0, res_valid_o}, 64'd1);
        check("lat_data", {32'd0, res_data_o}, 64'hAAAA0001);
        wait_idle(20);
        check("single_done", 64'(done_cnt - d0), 64'd1);
        check("single_busy", {63'd0, busy_o}, 64'd0);

        // Four words, full throughput
        c0 = csb_cnt; r0 = res_cnt; d0 = done_cnt;
        start_xfer(9'h000, 9'h003);
        wait_idle(40);
        check("multi_csb", 64'(csb_cnt - c0), 64'd4);
        check("multi_res", 64'(res_cnt - r0), 64'd8);
        check("multi_done", 64'(done_cnt - d0), 64'd1);

        // Backpressure during LO of word 0
        res_ready_i = 1'b0;
        c0 = csb_cnt; r0 = res_cnt;
        start_xfer(9'h020, 9'h021);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (res_valid_o) begin found = 1'b1; break; end
            step();
        end
        check("bp_valid_seen", {63'd0, found}, 64'd1);
        held = res_data_o;
        check("bp_lo_data", {32'd0, held}, {32'd0, mem[9'h020][31:0]});
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_data", {32'd0, res_data_o}, {32'd0, held});
            check("bp_hold_valid", {63'd0, res_valid_o}, 64'd1);
        end
        check("bp_no_extra_csb", 64'(csb_cnt - c0), 64'd1);
        check("bp_no_result", 64'(res_cnt - r0), 64'd0);
        res_ready_i = 1'b1;
        wait_idle(40);
        check("bp_res", 64'(res_cnt - r0), 64'd4);

        // Address wrap
        c0 = csb_cnt; r0 = res_cnt;
        start_xfer(9'h1FE, 9'h001);
        wait_idle(40);
        check("wrap_csb", 64'(csb_cnt - c0), 64'd4);
        check("wrap_res", 64'(res_cnt - r0), 64'd8);

        // Reset in HI of word 2, then restart elsewhere
        start_xfer(9'h040, 9'h045);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (res_valid_o && res_data_o == mem[9'h042][63:32]) begin found = 1'b1; break; end
            step();
        end
        check("rst_hi_seen", {63'd0, found}, 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {63'd0, res_valid_o}, 64'd0);
        check("mid_rst_data", {32'd0, res_data_o}, 64'd0);
        check("mid_rst_busy", {63'd0, busy_o}, 64'd0);
        check("mid_rst_csb", {63'd0, csb_o}, 64'd1);
        check("mid_rst_addr", {55'd0, addr_o}, 64'd0);
        exp_q.delete();
        addr_q.delete();
        step();
        rst = 1'b0;
        step();
        r0 = res_cnt;
        start_xfer(9'h050, 9'h050);
        wait_idle(20);
        check("post_rst_res", 64'(res_cnt - r0), 64'd2);

        // Start while busy and start in DONE are ignored
        c0 = csb_cnt; r0 = res_cnt;
        start_xfer(9'h060, 9'h061);
        step();
        start_i = 1'b1; start_addr_i = 9'h070; end_addr_i = 9'h075;
        step();
        start_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done_o) begin found = 1'b1; break; end
            step();
        end
        check("busy_done_seen", {63'd0, found}, 64'd1);
        start_i = 1'b1; start_addr_i = 9'h080; end_addr_i = 9'h080;
        step();
        start_i = 1'b0;
        step();
        step();
        check("ign_busy", {63'd0, busy_o}, 64'd0);
        check("ign_csb", 64'(csb_cnt - c0), 64'd2);
        check("ign_res", 64'(res_cnt - r0), 64'd4);
        check("ign_queue", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
